dmem_ctrl: RTL

- Multi-cycle data-memory controller sitting directly downstream of the ALU.
- ALUResult is the byte address; rt data is the store data.
- Owns an internal word-addressed RAM and serves one load or store at a time.
- Holds the core with a stall output while an access is pending, which models a non-ideal memory latency for the single-cycle datapath.

---
 rtl/dmem_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller with internal word RAM and core stall.
// Optional byte-lane store enables: define DMEM_BYTE_EN_EN.
`timescale 1ns/1ps
module dmem_ctrl #(
  parameter int data_size   = 32,
  parameter int mem_depth   = 64,
  parameter int wait_cycles = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [data_size-1:0] Addr,
  input  logic [data_size-1:0] WriteData,
  input  logic                 MemWrite,
  input  logic                 MemRead,
`ifdef DMEM_BYTE_EN_EN
  input  logic [3:0]           ByteEn,
`endif
  output logic [data_size-1:0] ReadData,
  output logic                 mem_stall,
  output logic                 mem_done,
  output logic                 misalign_err
);

  localparam int aw = $clog2(mem_depth);
  localparam bit no_wait = (wait_cycles == 0);
  localparam logic [3:0] last =
    4'((wait_cycles == 0) ? 0 : wait_cycles - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_nxt;

  logic                 req;
  logic                 mis_in;
  logic [aw-1:0]        idx_in;
  logic [aw-1:0]        idx_q;
  logic [data_size-1:0] data_q;
  logic                 we_q;
  logic                 mis_q;
  logic [3:0]           cnt;
`ifdef DMEM_BYTE_EN_EN
  logic [3:0]           be_q;
`endif

  logic                 cm_en;
  logic                 cm_we;
  logic [aw-1:0]        cm_idx;
  logic [data_size-1:0] cm_data;
  logic [data_size-1:0] cm_mask;

  logic [data_size-1:0] mem [mem_depth];

  // high address bits only select aliases of the same word
  logic unused_addr;
  assign unused_addr = ^Addr[data_size-1:aw+2];

  assign req    = MemRead | MemWrite;
  assign mis_in = |Addr[1:0];
  assign idx_in = Addr[aw+1:2];

`ifdef DMEM_BYTE_EN_EN
  function automatic logic [data_size-1:0] lanes(
    input logic [3:0] be
  );
    lanes = '0;
    for (int i = 0; i < 4; i++)
      if (be[i]) lanes[8*i +: 8] = 8'hFF;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req)
              state_nxt = (mis_in || no_wait) ? DONE : WAIT;
      WAIT: if (cnt == last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_stall    = 1'b0;
    mem_done     = 1'b0;
    misalign_err = 1'b0;
    unique case (state)
      IDLE: mem_stall = req & rst;
      WAIT: mem_stall = 1'b1;
      DONE: begin
        mem_done     = 1'b1;
        misalign_err = mis_q;
      end
      default: ;
    endcase
  end

  // commit happens on the edge that enters DONE
  always_comb begin
    cm_en   = 1'b0;
    cm_we   = we_q;
    cm_idx  = idx_q;
    cm_data = data_q;
`ifdef DMEM_BYTE_EN_EN
    cm_mask = lanes(be_q);
`else
    cm_mask = '1;
`endif
    unique case (state)
      IDLE: if (req && no_wait && !mis_in) begin
        cm_en   = 1'b1;
        cm_we   = MemWrite;
        cm_idx  = idx_in;
        cm_data = WriteData;
`ifdef DMEM_BYTE_EN_EN
        cm_mask = lanes(ByteEn);
`endif
      end
      WAIT: cm_en = (cnt == last);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      mis_q  <= 1'b0;
      cnt    <= '0;
`ifdef DMEM_BYTE_EN_EN
      be_q   <= '0;
`endif
    end else if (state == IDLE && req) begin
      idx_q  <= idx_in;
      data_q <= WriteData;
      we_q   <= MemWrite;
      mis_q  <= mis_in;
      cnt    <= '0;
`ifdef DMEM_BYTE_EN_EN
      be_q   <= ByteEn;
`endif
    end else if (state == WAIT) begin
      cnt <= cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < mem_depth; i++) mem[i] <= '0;
      ReadData <= '0;
    end else if (cm_en) begin
      if (cm_we)
        mem[cm_idx] <= (mem[cm_idx] & ~cm_mask)
                     | (cm_data & cm_mask);
      else
        ReadData <= mem[cm_idx];
    end
  end

endmodule
